peripheral_ahb_slave_mem: RTL



---
 rtl/peripheral_ahb_slave_mem.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/peripheral_ahb_slave_mem.sv
// AHB-Lite completer backed by an on-chip word memory.
// Adds a fixed number of wait states to OKAY transfers and answers illegal transfers with the two-cycle ERROR response.
module peripheral_ahb_slave_mem #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES    = HDATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int OFF_W    = (ADDR_LSB > 0) ? ADDR_LSB : 1;
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [2:0]       size_q, size_d;
  logic             write_q, write_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;

  logic             accept;
  logic             illegal;
  logic             mem_we;
  logic [BYTES-1:0] lane_hit;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Only the ready states (IDLE, DATA, ERR2) can take a new address phase.
  assign accept = HSEL && HREADY && HTRANS[1] && hreadyout_q;

  always_comb begin
    illegal = 1'b0;
    if (32'(HADDR >> ADDR_LSB) >= 32'(MEM_DEPTH)) illegal = 1'b1;
    if ((32'd8 << HSIZE) > 32'(HDATA_SIZE)) illegal = 1'b1;
    if ((HADDR & ((HADDR_SIZE'(1) << HSIZE) - HADDR_SIZE'(1))) != '0) illegal = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_DATA;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept) begin
          idx_d   = IDX_W'(HADDR >> ADDR_LSB);
          off_d   = OFF_W'(HADDR & HADDR_SIZE'(BYTES - 1));
          size_d  = HSIZE;
          write_d = HWRITE;
          cnt_d   = '0;
          if (illegal)              state_d = S_ERR1;
          else if (WAIT_STATES > 0) state_d = S_WAIT;
          else                      state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign lane_hit[gi] = (32'(gi) >= 32'(off_q)) &&
                          (32'(gi) < 32'(off_q) + (32'd1 << size_q));
  end

  // Reset forces state_q out of DATA at once, so an interrupted write never reaches memory.
  assign mem_we = (state_q == S_DATA) && write_q;

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lane_hit[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Asynchronous read lets a read accepted on a write's commit edge see the new word.
  assign HRDATA    = (state_q == S_DATA) ? mem[idx_q] : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule
